// File: rtl/addsub_serial.sv
// addsub_serial: digit-serial two's-complement adder/subtractor.
// Operands are consumed LSB-first, DIGIT bits per clock, behind a
// start/busy/done handshake. Subtraction uses A + ~B + 1, and the
// signed-overflow flag can optionally clamp the result.
module addsub_serial #(
    parameter int WIDTH    = 8,
    parameter int DIGIT    = 2,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] SD,
    output logic             Co,
    output logic             Err
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state, state_nxt;

    // Operand registers shift right, so the slice being processed is
    // always in the low DIGIT bits. The accumulator fills from the top.
    logic [WIDTH-1:0] a_q, bx_q, acc_q;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;

    logic               accept;
    logic               last;
    logic [DIGIT:0]     ssum;
    logic               msb_cin;
    logic [WIDTH+DIGIT-1:0] acc_cat;
    logic [WIDTH-1:0]   acc_nxt;
    logic               ovf;

    // Clamp to the signed limit on overflow; the sign of A selects which
    // limit, since overflow always pushes the result away from A's sign.
    function automatic logic [WIDTH-1:0] sat_result(
        input logic [WIDTH-1:0] wrapped,
        input logic             overflow,
        input logic             a_msb
    );
        logic signed [WIDTH-1:0] smax;
        logic signed [WIDTH-1:0] smin;
        smax = {1'b0, {(WIDTH-1){1'b1}}};
        smin = {1'b1, {(WIDTH-1){1'b0}}};
        if ((SATURATE != 0) && overflow) begin
            return a_msb ? smin : smax;
        end
        return wrapped;
    endfunction

    assign accept  = start && ((state == IDLE) || (state == DONE));
    assign last    = (cnt_q == CW'(NDIG - 1));
    assign ssum    = {1'b0, a_q[DIGIT-1:0]} + {1'b0, bx_q[DIGIT-1:0]}
                   + {{DIGIT{1'b0}}, carry_q};
    // Carry into the word MSB, recovered from the top bit of the slice.
    assign msb_cin = a_q[DIGIT-1] ^ bx_q[DIGIT-1] ^ ssum[DIGIT-1];
    assign acc_cat = {ssum[DIGIT-1:0], acc_q};
    assign acc_nxt = acc_cat[WIDTH+DIGIT-1:DIGIT];
    assign ovf     = msb_cin ^ ssum[DIGIT];

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = start ? RUN : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand latch and per-slice add with carry propagation.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q     <= '0;
            bx_q    <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else if (accept) begin
            a_q     <= A;
            bx_q    <= sub ? ~B : B;
            acc_q   <= '0;
            carry_q <= sub;
            cnt_q   <= '0;
        end else if (state == RUN) begin
            a_q     <= a_q >> DIGIT;
            bx_q    <= bx_q >> DIGIT;
            acc_q   <= acc_nxt;
            carry_q <= ssum[DIGIT];
            cnt_q   <= cnt_q + CW'(1);
        end
    end

    // Result registers: only written on the edge that completes an
    // operation, so partial sums are never visible.
    always_ff @(posedge clk) begin
        if (reset) begin
            SD  <= '0;
            Co  <= 1'b0;
            Err <= 1'b0;
        end else if ((state == RUN) && last) begin
            SD  <= sat_result(acc_nxt, ovf, a_q[DIGIT-1]);
            Co  <= ssum[DIGIT];
            Err <= ovf;
        end
    end

endmodule
